// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez RAM arbiter: default widths, owner
// state encodings, requester ids and the RAM rw encoding.
package simplez_pkg;

    localparam int unsigned AW_DEF = 9;
    localparam int unsigned DW_DEF = 12;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_owner_e;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/simplez_arb_pick.sv
// Combinational winner select for the Simplez RAM arbiter.
// Optional macro SIMPLEZ_ARB_RR_EN: round-robin on an idle tie instead of
// fixed M0 priority.
module simplez_arb_pick
    import simplez_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HW       = $clog2(MAX_HOLD) + 1
) (
    input  logic [1:0]    req_i,
    input  arb_owner_e    owner_i,
    input  logic [HW-1:0] hold_cnt_i,
    input  req_id_e       last_i,
    output logic [1:0]    gnt_o
);

    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

`ifndef SIMPLEZ_ARB_RR_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    // Lone requester wins; on contention the owner keeps the port until its hold limit.
    always_comb begin
        gnt_o = '0;
        if (req_i == 2'b01) begin
            gnt_o = 2'b01;
        end else if (req_i == 2'b10) begin
            gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            case (owner_i)
                ARB_OWN0: gnt_o = (hold_cnt_i < HOLD_LIM) ? 2'b01 : 2'b10;
                ARB_OWN1: gnt_o = (hold_cnt_i < HOLD_LIM) ? 2'b10 : 2'b01;
                default: begin
`ifdef SIMPLEZ_ARB_RR_EN
                    gnt_o = (last_i == REQ_M0) ? 2'b10 : 2'b01;
`else
                    gnt_o = 2'b01;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/simplez_ram_arbiter.sv
// Two-requester arbiter for the single-port Simplez program RAM.
// Optional macro SIMPLEZ_ARB_RR_EN selects round-robin idle tie-break.
module simplez_ram_arbiter
    import simplez_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam int unsigned   HW       = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    arb_owner_e    owner_q, owner_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    req_id_e       last_q, last_d;
    logic [1:0]    rd_pend_q, rd_pend_d;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;
    logic [1:0]    pick_gnt;
    logic [1:0]    gnt;

    simplez_arb_pick #(
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) u_pick (
        .req_i      ({m1_req, m0_req}),
        .owner_i    (owner_q),
        .hold_cnt_i (hold_cnt_q),
        .last_i     (last_q),
        .gnt_o      (pick_gnt)
    );

    // Grants are suppressed while reset is held so the RAM sees no access.
    assign gnt    = rst ? 2'b00 : pick_gnt;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign ram_cs = |gnt;

    // Route the winner's address, data and direction onto the RAM port.
    always_comb begin
        ram_rw   = RW_READ;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt[0]) begin
            ram_rw   = m0_we ? RW_WRITE : RW_READ;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (gnt[1]) begin
            ram_rw   = m1_we ? RW_WRITE : RW_READ;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Next owner, hold count, last winner and read-pending flags.
    always_comb begin
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        rd_pend_d  = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};
        if (gnt[0]) begin
            last_d = REQ_M0;
            if (owner_q == ARB_OWN0) begin
                if (hold_cnt_q < HOLD_LIM) hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                owner_d    = ARB_OWN0;
                hold_cnt_d = '0;
            end
        end else if (gnt[1]) begin
            last_d = REQ_M1;
            if (owner_q == ARB_OWN1) begin
                if (hold_cnt_q < HOLD_LIM) hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                owner_d    = ARB_OWN1;
                hold_cnt_d = '0;
            end
        end else begin
            owner_d    = ARB_IDLE;
            hold_cnt_d = '0;
        end
    end

    // Arbitration state register; reset drops any pending read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= ARB_IDLE;
            hold_cnt_q <= '0;
            last_q     <= REQ_M1;
            rd_pend_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Per-port read data hold registers, loaded when that port's response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (rd_pend_q[0]) m0_rdata_q <= ram_dout;
            if (rd_pend_q[1]) m1_rdata_q <= ram_dout;
        end
    end

    assign m0_rvalid = ~rst & rd_pend_q[0];
    assign m1_rvalid = ~rst & rd_pend_q[1];
    assign m0_rdata  = rst ? '0 : (rd_pend_q[0] ? ram_dout : m0_rdata_q);
    assign m1_rdata  = rst ? '0 : (rd_pend_q[1] ? ram_dout : m1_rdata_q);
    assign busy      = ~rst & (|rd_pend_q);

endmodule

// File: tb/tb_simplez_ram_arbiter.sv
// Self-checking bench for simplez_ram_arbiter with a behavioural 512x12 RAM
// and a per-port read-data scoreboard.
module tb_simplez_ram_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_cs, ram_rw, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] mem    [0:511];
    logic [DW-1:0] shadow [0:511];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    simplez_ram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        if (a == 5) return 12'hA5C;
        return DW'(a * 37 + 241);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
    end

    // Behavioural synchronous RAM
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rw == 1'b0) mem[ram_addr] <= ram_din;
            else                ram_dout      <= mem[ram_addr];
        end
    end

    // Scoreboard: pop on rvalid, push expected data on each read grant
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (m0_rvalid) begin
                checks++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL sb_m0_unexpected rvalid with data %h, none expected", m0_rdata);
                end else begin
                    logic [DW-1:0] e0;
                    e0 = q0.pop_front();
                    if (m0_rdata !== e0) begin
                        fails++;
                        $display("FAIL sb_m0_data got %h expected %h", m0_rdata, e0);
                    end
                end
            end
            if (m1_rvalid) begin
                checks++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL sb_m1_unexpected rvalid with data %h, none expected", m1_rdata);
                end else begin
                    logic [DW-1:0] e1;
                    e1 = q1.pop_front();
                    if (m1_rdata !== e1) begin
                        fails++;
                        $display("FAIL sb_m1_data got %h expected %h", m1_rdata, e1);
                    end
                end
            end
            if (m0_gnt) begin
                if (m0_we) shadow[m0_addr] = m0_wdata;
                else       q0.push_back(shadow[m0_addr]);
            end
            if (m1_gnt) begin
                if (m1_we) shadow[m1_addr] = m1_wdata;
                else       q1.push_back(shadow[m1_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 9'h005;
        m1_req = 1'b1; m1_addr = 9'h006;
        step();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, ram_cs, ram_rw, m0_rvalid, m1_rvalid, busy} !== 7'b0001000) begin
            fails++;
            $display("FAIL reset_ctrl got %b expected 0001000",
                     {m0_gnt, m1_gnt, ram_cs, ram_rw, m0_rvalid, m1_rvalid, busy});
        end
        checks++;
        if ({ram_addr, ram_din, m0_rdata, m1_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_data got addr %h din %h r0 %h r1 %h expected all 0",
                     ram_addr, ram_din, m0_rdata, m1_rdata);
        end
        step();
        rst = 1'b0;
        idle_reqs();
    endtask

    task automatic test_read_m0();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h005;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, ram_cs, ram_rw} !== 4'b1011 || ram_addr !== 9'h005) begin
            fails++;
            $display("FAIL read_m0_grant got gnt0 %b gnt1 %b cs %b rw %b addr %h expected 1 0 1 1 005",
                     m0_gnt, m1_gnt, ram_cs, ram_rw, ram_addr);
        end
        step();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 12'hA5C || busy !== 1'b1 || m1_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL read_m0_resp got rvalid %b data %h busy %b rvalid1 %b expected 1 a5c 1 0",
                     m0_rvalid, m0_rdata, busy, m1_rvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 12'hA5C || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_m0_hold got rvalid %b data %h busy %b expected 0 a5c 0",
                     m0_rvalid, m0_rdata, busy);
        end
    endtask

    task automatic test_write_m1();
        step();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h010; m1_wdata = 12'h123;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, ram_cs, ram_rw} !== 4'b0110 || ram_din !== 12'h123 || ram_addr !== 9'h010) begin
            fails++;
            $display("FAIL write_m1 got gnt0 %b gnt1 %b cs %b rw %b addr %h din %h expected 0 1 1 0 010 123",
                     m0_gnt, m1_gnt, ram_cs, ram_rw, ram_addr, ram_din);
        end
        step();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m1_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL write_no_resp got busy %b rvalid1 %b expected 0 0", busy, m1_rvalid);
        end
        step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
        step();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 12'h123) begin
            fails++;
            $display("FAIL write_readback got rvalid %b data %h expected 1 123", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp_g;
        step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h020;
        for (int j = 0; j < 12; j++) begin
            if (j == 1) begin
                m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h030;
            end
            exp_g = ((j >= 4) && (j < 8)) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_g || ram_cs !== 1'b1) begin
                fails++;
                $display("FAIL hold_pattern cycle %0d got gnt %b cs %b expected %b 1",
                         j, {m1_gnt, m0_gnt}, ram_cs, exp_g);
            end
            step();
        end
        idle_reqs();
        step();
    endtask

    task automatic test_tie();
        logic [1:0] exp_first;
`ifdef SIMPLEZ_ARB_RR_EN
        exp_first = 2'b10;
`else
        exp_first = 2'b01;
`endif
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h040; m0_wdata = 12'h0AA;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h041; m1_wdata = 12'h055;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== exp_first) begin
            fails++;
            $display("FAIL tie_first got gnt %b expected %b", {m1_gnt, m0_gnt}, exp_first);
        end
        step();
        if (exp_first == 2'b01) m0_req = 1'b0;
        else                    m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== ~exp_first) begin
            fails++;
            $display("FAIL tie_second got gnt %b expected %b", {m1_gnt, m0_gnt}, ~exp_first);
        end
        step();
        idle_reqs();
        step();
    endtask

    task automatic test_alternate();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h001;
        step();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h002;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== init_val(1)) begin
            fails++;
            $display("FAIL alt_a got gnt1 %b rv0 %b rv1 %b d0 %h expected 1 1 0 %h",
                     m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, init_val(1));
        end
        step();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 9'h003;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== init_val(2)) begin
            fails++;
            $display("FAIL alt_b got gnt0 %b rv0 %b rv1 %b d1 %h expected 1 0 1 %h",
                     m0_gnt, m0_rvalid, m1_rvalid, m1_rdata, init_val(2));
        end
        step();
        idle_reqs();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== init_val(3) || m1_rdata !== init_val(2)) begin
            fails++;
            $display("FAIL alt_c got rv0 %b rv1 %b d0 %h d1 %h expected 1 0 %h %h",
                     m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, init_val(3), init_val(2));
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h007;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_grant got gnt1 %b expected 1", m1_gnt);
        end
        step();
        idle_reqs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b0 || busy !== 1'b0 || m1_rdata !== '0) begin
            fails++;
            $display("FAIL rstmid_drop got rv1 %b busy %b d1 %h expected 0 0 000", m1_rvalid, busy, m1_rdata);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m1_rvalid, ram_cs, ram_rw} !== 5'b00001) begin
            fails++;
            $display("FAIL rstmid_after got %b expected 00001", {m0_gnt, m1_gnt, m1_rvalid, ram_cs, ram_rw});
        end
        // Fresh IDLE with last=M1: an idle tie goes to M0 in either tie-break mode
        step();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h050; m0_wdata = 12'h111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h051; m1_wdata = 12'h222;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_tie got gnt %b expected 01", {m1_gnt, m0_gnt});
        end
        step();
        idle_reqs();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_m0();
        test_write_m1();
        test_hold();
        test_tie();
        test_alternate();
        test_reset_mid_read();
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
